// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit CPU: opcodes, instruction field positions,
// and the data-processing immediate rotate helper.
package cpu_pkg;

   localparam int DW_DEF   = 32;
   localparam int AW_DEF   = 4;
   localparam int NREG_DEF = 16;

   typedef enum logic [3:0] {
      OP_AND = 4'd0,
      OP_EOR = 4'd1,
      OP_SUB = 4'd2,
      OP_RSB = 4'd3,
      OP_ADD = 4'd4,
      OP_ADC = 4'd5,
      OP_SBC = 4'd6,
      OP_RSC = 4'd7,
      OP_TST = 4'd8,
      OP_TEQ = 4'd9,
      OP_CMP = 4'd10,
      OP_CMN = 4'd11,
      OP_ORR = 4'd12,
      OP_MOV = 4'd13,
      OP_BIC = 4'd14,
      OP_MVN = 4'd15
   } opcode_e;

   localparam int CLASS_HI = 27;
   localparam int CLASS_LO = 26;
   localparam int I_BIT    = 25;
   localparam int OPC_HI   = 24;
   localparam int OPC_LO   = 21;
   localparam int S_BIT    = 20;
   localparam int RN_HI    = 19;
   localparam int RN_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 12;
   localparam int ROT_HI   = 11;
   localparam int ROT_LO   = 8;
   localparam int IMM_HI   = 7;
   localparam int IMM_LO   = 0;
   localparam int RM_HI    = 3;
   localparam int RM_LO    = 0;

   localparam logic [1:0] CLASS_DP = 2'b00;

   // Rotating a doubled copy right and keeping the low half gives a true rotate.
   function automatic logic [31:0] rotate_imm(input logic [7:0] imm8, input logic [3:0] rot);
      return 32'({24'b0, imm8, 24'b0, imm8} >> {rot, 1'b0});
   endfunction

endpackage

// File: rtl/scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A set and a clear of the same register in one cycle leaves it busy.
module scoreboard
   import cpu_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [AW-1:0]   set_addr,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_addr,
   output logic [NREG-1:0] busy
);

   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] busy_q;

   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes data-processing instructions, stalls on register
// hazards against the scoreboard, and registers operands into the execute slot.
module id_issue_stage
   import cpu_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [DW-1:0]   in_instr,
   output logic            in_ready,
   output logic [AW-1:0]   rf_read_addr1,
   output logic [AW-1:0]   rf_read_addr2,
   output logic            rf_read_enable,
   input  logic [DW-1:0]   rf_read_data1,
   input  logic [DW-1:0]   rf_read_data2,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [3:0]      ex_opcode,
   output logic            ex_set_flags,
   output logic [AW-1:0]   ex_rd,
   output logic            ex_we,
   output logic [DW-1:0]   ex_op_a,
   output logic [DW-1:0]   ex_op_b,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_addr,
   output logic [NREG-1:0] busy_mask
);

   logic            is_dp;
   logic            imm_sel;
   logic            uses_rn;
   logic            uses_rm;
   logic            writes_rd;
   logic            hazard;
   logic            accept;
   opcode_e         opcode;
   logic [AW-1:0]   rn;
   logic [AW-1:0]   rd;
   logic [AW-1:0]   rm;
   logic [NREG-1:0] busy;
   logic            unused_cond;

   logic            ex_valid_d,     ex_valid_q;
   opcode_e         ex_opcode_d,    ex_opcode_q;
   logic            ex_set_flags_d, ex_set_flags_q;
   logic [AW-1:0]   ex_rd_d,        ex_rd_q;
   logic            ex_we_d,        ex_we_q;
   logic [DW-1:0]   ex_op_a_d,      ex_op_a_q;
   logic [DW-1:0]   ex_op_b_d,      ex_op_b_q;

   assign unused_cond = ^in_instr[31:28];

   // The hazard check uses registered busy bits only, so a same-cycle writeback
   // cannot release a stalled instruction until the following cycle.
   always_comb begin
      is_dp     = (in_instr[CLASS_HI:CLASS_LO] == CLASS_DP);
      imm_sel   = in_instr[I_BIT];
      opcode    = opcode_e'(in_instr[OPC_HI:OPC_LO]);
      rn        = AW'(in_instr[RN_HI:RN_LO]);
      rd        = AW'(in_instr[RD_HI:RD_LO]);
      rm        = AW'(in_instr[RM_HI:RM_LO]);
      uses_rn   = is_dp && !(opcode inside {OP_MOV, OP_MVN});
      uses_rm   = is_dp && !imm_sel;
      writes_rd = is_dp && !(opcode inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
      hazard    = (uses_rn && busy[rn]) || (uses_rm && busy[rm]) || (writes_rd && busy[rd]);
      in_ready  = !hazard && (!ex_valid_q || ex_ready);
      accept    = in_valid && in_ready;
   end

   always_comb begin
      ex_valid_d     = ex_valid_q;
      ex_opcode_d    = ex_opcode_q;
      ex_set_flags_d = ex_set_flags_q;
      ex_rd_d        = ex_rd_q;
      ex_we_d        = ex_we_q;
      ex_op_a_d      = ex_op_a_q;
      ex_op_b_d      = ex_op_b_q;
      if (accept) begin
         ex_valid_d     = 1'b1;
         ex_opcode_d    = opcode;
         ex_set_flags_d = in_instr[S_BIT];
         ex_rd_d        = rd;
         ex_we_d        = writes_rd;
         ex_op_a_d      = is_dp ? rf_read_data1 : '0;
         if (!is_dp)       ex_op_b_d = '0;
         else if (imm_sel) ex_op_b_d = DW'(rotate_imm(in_instr[IMM_HI:IMM_LO], in_instr[ROT_HI:ROT_LO]));
         else              ex_op_b_d = rf_read_data2;
      end else if (ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid_q     <= 1'b0;
         ex_opcode_q    <= OP_AND;
         ex_set_flags_q <= 1'b0;
         ex_rd_q        <= '0;
         ex_we_q        <= 1'b0;
         ex_op_a_q      <= '0;
         ex_op_b_q      <= '0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_opcode_q    <= ex_opcode_d;
         ex_set_flags_q <= ex_set_flags_d;
         ex_rd_q        <= ex_rd_d;
         ex_we_q        <= ex_we_d;
         ex_op_a_q      <= ex_op_a_d;
         ex_op_b_q      <= ex_op_b_d;
      end
   end

   scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (accept && writes_rd),
      .set_addr (rd),
      .clr_en   (wb_valid),
      .clr_addr (wb_addr),
      .busy     (busy)
   );

   assign rf_read_addr1  = rn;
   assign rf_read_addr2  = rm;
   assign rf_read_enable = in_valid;
   assign ex_valid       = ex_valid_q;
   assign ex_opcode      = ex_opcode_q;
   assign ex_set_flags   = ex_set_flags_q;
   assign ex_rd          = ex_rd_q;
   assign ex_we          = ex_we_q;
   assign ex_op_a        = ex_op_a_q;
   assign ex_op_b        = ex_op_b_q;
   assign busy_mask      = busy;

endmodule
